// File: rtl/ps2_char_decoder.sv
// PS/2 scan-code to character translator feeding a small first-word-fall-through FIFO.
// Tracks both shift keys, maps make events to ASCII/control codes and drops on overflow.
module ps2_char_decoder #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] key,
   input  logic        key_pressed,
   input  logic        new_key,
   output logic [7:0]  char,
   output logic        char_valid,
   input  logic        char_ready,
   output logic        shift_active,
   output logic        overflow
);

   localparam int              PTR_W    = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]  DEPTH_C  = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [15:0]     KEY_SHIFT_L = 16'h0012;
   localparam logic [15:0]     KEY_SHIFT_R = 16'h0059;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             shift_l_q, shift_l_d;
   logic             shift_r_q, shift_r_d;
   logic             overflow_q, overflow_d;

   logic             map_hit;
   logic [7:0]       map_char;
   logic             shifted;
   logic             push_req;
   logic             push_acc;
   logic             pop;
   logic             full;

   assign shifted = shift_l_q | shift_r_q;

   // Shift-independent codes are resolved first; shift keys themselves never map.
   always_comb begin
      map_hit  = 1'b1;
      map_char = 8'h00;
      case (key)
         16'h007C: map_char = 8'h2A;
         16'h0079: map_char = 8'h2B;
         16'h007B: map_char = 8'h2D;
         16'hE04A: map_char = 8'h2F;
         16'hE05A: map_char = 8'h0A;
         16'hE075: map_char = 8'h11;
         16'hE072: map_char = 8'h12;
         16'hE06B: map_char = 8'h13;
         16'hE074: map_char = 8'h14;
         16'h005A: map_char = 8'h0A;
         16'h0066: map_char = 8'h08;
         default: begin
            if (shifted) begin
               case (key)
                  16'h003E: map_char = 8'h2A;
                  16'h0046: map_char = 8'h28;
                  16'h0045: map_char = 8'h29;
                  16'h0036: map_char = 8'h5E;
                  16'h0055: map_char = 8'h2B;
                  16'h0022: map_char = 8'h58;
                  default:  map_hit  = 1'b0;
               endcase
            end else begin
               case (key)
                  16'h0045: map_char = 8'h30;
                  16'h0016: map_char = 8'h31;
                  16'h001E: map_char = 8'h32;
                  16'h0026: map_char = 8'h33;
                  16'h0025: map_char = 8'h34;
                  16'h002E: map_char = 8'h35;
                  16'h0036: map_char = 8'h36;
                  16'h003D: map_char = 8'h37;
                  16'h003E: map_char = 8'h38;
                  16'h0046: map_char = 8'h39;
                  16'h0022: map_char = 8'h78;
                  16'h004E: map_char = 8'h2D;
                  16'h0055: map_char = 8'h3D;
                  16'h004A: map_char = 8'h2F;
                  16'h0049: map_char = 8'h2E;
                  default:  map_hit  = 1'b0;
               endcase
            end
         end
      endcase
   end

   assign push_req = new_key && key_pressed && map_hit;
   assign pop      = (count_q != '0) && char_ready;
   assign full     = (count_q == DEPTH_C);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_acc = push_req && (!full || pop);

   always_comb begin
      shift_l_d  = shift_l_q;
      shift_r_d  = shift_r_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      if (new_key && (key == KEY_SHIFT_L)) shift_l_d = key_pressed;
      if (new_key && (key == KEY_SHIFT_R)) shift_r_d = key_pressed;

      if (push_acc) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop)      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;

      case ({push_acc, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (push_req && full && !pop) overflow_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         shift_l_q  <= 1'b0;
         shift_r_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         shift_l_q  <= shift_l_d;
         shift_r_q  <= shift_r_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset: occupancy alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push_acc) mem[wr_ptr_q] <= map_char;
   end

   assign char_valid   = (count_q != '0);
   assign char         = char_valid ? mem[rd_ptr_q] : 8'h00;
   assign shift_active = shifted;
   assign overflow     = overflow_q;

endmodule

// File: tb/tb_ps2_char_decoder.sv
// Bench for ps2_char_decoder: directed scenarios with literal expectations, then random
// traffic compared every cycle against a queue-based reference model.
module tb_ps2_char_decoder;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] key = 16'h0000;
   logic        key_pressed = 1'b0;
   logic        new_key = 1'b0;
   logic [7:0]  char;
   logic        char_valid;
   logic        char_ready = 1'b0;
   logic        shift_active;
   logic        overflow;

   ps2_char_decoder #(.FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .key          (key),
      .key_pressed  (key_pressed),
      .new_key      (new_key),
      .char         (char),
      .char_valid   (char_valid),
      .char_ready   (char_ready),
      .shift_active (shift_active),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   // Translation tables written straight from the key map.
   localparam logic [15:0] DIG_CODES [10] = '{16'h0045, 16'h0016, 16'h001E, 16'h0026, 16'h0025,
                                             16'h002E, 16'h0036, 16'h003D, 16'h003E, 16'h0046};
   localparam logic [15:0] ANY_CODES [9]  = '{16'h007C, 16'h0079, 16'h007B, 16'hE04A, 16'hE05A,
                                             16'hE075, 16'hE072, 16'hE06B, 16'hE074};
   localparam logic [7:0]  ANY_CHARS [9]  = '{8'h2A, 8'h2B, 8'h2D, 8'h2F, 8'h0A, 8'h11, 8'h12, 8'h13, 8'h14};
   localparam logic [15:0] UNS_CODES [7]  = '{16'h0022, 16'h004E, 16'h0055, 16'h004A, 16'h0049, 16'h005A, 16'h0066};
   localparam logic [7:0]  UNS_CHARS [7]  = '{8'h78, 8'h2D, 8'h3D, 8'h2F, 8'h2E, 8'h0A, 8'h08};
   localparam logic [15:0] SH_CODES [8]   = '{16'h003E, 16'h0046, 16'h0045, 16'h0036, 16'h0055, 16'h0022, 16'h005A, 16'h0066};
   localparam logic [7:0]  SH_CHARS [8]   = '{8'h2A, 8'h28, 8'h29, 8'h5E, 8'h2B, 8'h58, 8'h0A, 8'h08};

   byte unsigned q[$];
   bit  m_shl, m_shr, m_ovf;
   bit  chk_en = 1'b0;
   int  n_checks = 0;
   int  n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic bit xlate(input logic [15:0] k, input bit sh, output logic [7:0] c);
      c = 8'h00;
      for (int i = 0; i < 9; i++) if (k == ANY_CODES[i]) begin c = ANY_CHARS[i]; return 1'b1; end
      if (sh) begin
         for (int i = 0; i < 8; i++) if (k == SH_CODES[i]) begin c = SH_CHARS[i]; return 1'b1; end
      end else begin
         for (int i = 0; i < 10; i++) if (k == DIG_CODES[i]) begin c = 8'h30 + 8'(i); return 1'b1; end
         for (int i = 0; i < 7; i++) if (k == UNS_CODES[i]) begin c = UNS_CHARS[i]; return 1'b1; end
      end
      return 1'b0;
   endfunction

   task automatic model_clear();
      q.delete();
      m_shl = 1'b0;
      m_shr = 1'b0;
      m_ovf = 1'b0;
   endtask

   task automatic model_apply(input logic [15:0] k, input bit kp, input bit nk, input bit rdy);
      bit          do_pop, is_full, do_push;
      logic [7:0]  c;
      do_pop  = (q.size() != 0) && rdy;
      is_full = (q.size() == DEPTH);
      do_push = 1'b0;
      c       = 8'h00;
      if (nk) begin
         if (k == 16'h0012) m_shl = kp;
         else if (k == 16'h0059) m_shr = kp;
         else if (kp && xlate(k, m_shl | m_shr, c)) begin
            if (is_full && !do_pop) m_ovf = 1'b1;
            else do_push = 1'b1;
         end
      end
      if (do_pop) $display("pop char=%02h", q.pop_front());
      if (do_push) q.push_back(c);
   endtask

   task automatic cyc(input logic [15:0] k, input bit kp, input bit nk, input bit rdy);
      key         = k;
      key_pressed = kp;
      new_key     = nk;
      char_ready  = rdy;
      @(posedge clk);
      #1;
      model_apply(k, kp, nk, rdy);
      new_key = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_clear();
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("char_valid", {31'd0, char_valid}, {31'd0, q.size() != 0});
         if (q.size() != 0) chk("char", {24'd0, char}, {24'd0, q[0]});
         chk("shift_active", {31'd0, shift_active}, {31'd0, m_shl | m_shr});
         chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      end
   end

   function automatic logic [15:0] rand_key();
      int r;
      r = $urandom_range(0, 9);
      case (r)
         0:       return ($urandom_range(0, 1) != 0) ? 16'h0012 : 16'h0059;
         1, 2:    return DIG_CODES[$urandom_range(0, 9)];
         3:       return SH_CODES[$urandom_range(0, 7)];
         4:       return UNS_CODES[$urandom_range(0, 6)];
         5:       return ANY_CODES[$urandom_range(0, 8)];
         6:       return {8'h00, 8'($urandom_range(0, 255))};
         7:       return {8'hE0, 8'($urandom_range(0, 255))};
         8:       return {8'hE0, DIG_CODES[$urandom_range(0, 9)][7:0]};
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      int rdy_pct;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, char_valid}, 32'd0);
      chk("rst_char", {24'd0, char}, 32'h00);
      chk("rst_shift", {31'd0, shift_active}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      rst    = 1'b0;
      chk_en = 1'b1;

      // Single make, consumer ready: one-cycle latency, visible for exactly one cycle.
      cyc(16'h0016, 1, 1, 1);
      chk("s1_valid", {31'd0, char_valid}, 32'd1);
      chk("s1_char", {24'd0, char}, 32'h31);
      cyc(16'h0000, 0, 0, 1);
      chk("s1_gone", {31'd0, char_valid}, 32'd0);

      // Shift applies to the following event only while held.
      cyc(16'h0012, 1, 1, 1);
      chk("s2_shift_on", {31'd0, shift_active}, 32'd1);
      cyc(16'h0046, 1, 1, 1);
      chk("s2_char_paren", {24'd0, char}, 32'h28);
      chk("s2_shift_held", {31'd0, shift_active}, 32'd1);
      cyc(16'h0012, 0, 1, 1);
      chk("s2_shift_off", {31'd0, shift_active}, 32'd0);
      cyc(16'h0046, 1, 1, 1);
      chk("s2_char_nine", {24'd0, char}, 32'h39);
      cyc(16'h0000, 0, 0, 1);

      // Overflow with a stalled consumer, then drain in order.
      cyc(16'h0016, 1, 1, 0);
      cyc(16'h001E, 1, 1, 0);
      cyc(16'h0026, 1, 1, 0);
      cyc(16'h0025, 1, 1, 0);
      chk("s3_no_ovf_yet", {31'd0, overflow}, 32'd0);
      cyc(16'h002E, 1, 1, 0);
      chk("s3_ovf", {31'd0, overflow}, 32'd1);
      chk("s3_head", {24'd0, char}, 32'h31);
      for (int i = 0; i < 3; i++) begin
         cyc(16'h0000, 0, 0, 1);
         chk("s3_drain", {24'd0, char}, 32'h32 + 32'(i));
      end
      cyc(16'h0000, 0, 0, 1);
      chk("s3_empty", {31'd0, char_valid}, 32'd0);
      chk("s3_ovf_sticky", {31'd0, overflow}, 32'd1);

      // Reset mid-operation clears queue, shift and overflow.
      cyc(16'h0016, 1, 1, 0);
      cyc(16'h001E, 1, 1, 0);
      cyc(16'h0026, 1, 1, 0);
      cyc(16'h0059, 1, 1, 0);
      chk("s6_shift_held", {31'd0, shift_active}, 32'd1);
      do_reset();
      chk("s6_valid", {31'd0, char_valid}, 32'd0);
      chk("s6_shift", {31'd0, shift_active}, 32'd0);
      chk("s6_ovf", {31'd0, overflow}, 32'd0);
      cyc(16'h003E, 1, 1, 0);
      chk("s6_eight", {24'd0, char}, 32'h38);
      cyc(16'h0000, 0, 0, 1);

      // Push and pop together while full: both accepted, no overflow.
      cyc(16'h0016, 1, 1, 0);
      cyc(16'h001E, 1, 1, 0);
      cyc(16'h0026, 1, 1, 0);
      cyc(16'h0025, 1, 1, 0);
      cyc(16'h002E, 1, 1, 1);
      chk("s4_ovf", {31'd0, overflow}, 32'd0);
      chk("s4_head", {24'd0, char}, 32'h32);
      for (int i = 0; i < 3; i++) begin
         cyc(16'h0000, 0, 0, 1);
         chk("s4_drain", {24'd0, char}, 32'h33 + 32'(i));
      end
      cyc(16'h0000, 0, 0, 1);
      chk("s4_empty", {31'd0, char_valid}, 32'd0);

      // Extended codes, unmapped make and ignored break.
      cyc(16'hE075, 1, 1, 0);
      cyc(16'hE04A, 1, 1, 0);
      cyc(16'h001C, 1, 1, 0);
      cyc(16'h0016, 0, 1, 0);
      chk("s5_head", {24'd0, char}, 32'h11);
      cyc(16'h0000, 0, 0, 1);
      chk("s5_second", {24'd0, char}, 32'h2F);
      cyc(16'h0000, 0, 0, 1);
      chk("s5_empty", {31'd0, char_valid}, 32'd0);
      chk("s5_ovf", {31'd0, overflow}, 32'd0);

      // Random traffic with varying consumer throughput and occasional resets.
      rdy_pct = 50;
      for (int n = 0; n < 4000; n++) begin
         if (n % 250 == 0) rdy_pct = $urandom_range(5, 95);
         if ($urandom_range(0, 599) == 0) do_reset();
         else cyc(rand_key(), $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                  $urandom_range(0, 99) < rdy_pct);
      end

      @(posedge clk);
      #1;
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ps2_char_decoder.md
PS2_CHAR_DECODER -- requirements
Module: ps2_char_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of character FIFO entries; the legal values are powers of two from 2 to 16.
REQ-002 SHALL have port: clk  input  1  the only clock; all logic is on its rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: key  input  16  scan code; one-byte codes are zero-extended, extended codes are {8'hE0, code}.
REQ-005 SHALL have port: key_pressed  input  1  1 = make event, 0 = break event.
REQ-006 SHALL have port: new_key  input  1  a one-cycle strobe that qualifies key and key_pressed.
REQ-007 SHALL have port: char  output  8  head-of-FIFO character code.
REQ-008 SHALL have port: char_valid  output  1  the FIFO is non-empty and char is valid.
REQ-009 SHALL have port: char_ready  input  1  consumer accept; a pop occurs when char_valid && char_ready.
REQ-010 SHALL have port: shift_active  output  1  left or right shift is currently held.
REQ-011 SHALL have port: overflow  output  1  sticky flag set when a mapped character is dropped because the FIFO is full.

Function
REQ-012 SHALL track shift_l (key 16'h0012) and shift_r (key 16'h0059) as separate flags: set on make, clear on break; shift_active = shift_l | shift_r.
REQ-013 SHALL ignore break events for every key other than the shift keys.
REQ-014 SHALL translate unshifted make events as follows:
- digits 0x45,16,1E,26,25,2E,36,3D,3E,46 -> '0'..'9'
- 0x22 -> 'x'
- 0x4E -> '-'
- 0x55 -> '='
- 0x4A -> '/'
- 0x49 -> '.'
- 0x5A -> 8'h0A
- 0x66 -> 8'h08
REQ-015 SHALL translate shifted make events as follows:
- 0x3E -> '*'
- 0x46 -> '('
- 0x45 -> ')'
- 0x36 -> '^'
- 0x55 -> '+'
- 0x22 -> 'X'
- 0x5A -> 8'h0A
- 0x66 -> 8'h08
- every other code is unmapped
REQ-016 SHALL translate the following make events regardless of shift:
- keypad 0x7C -> '*'
- 0x79 -> '+'
- 0x7B -> '-'
- 16'hE04A -> '/'
- 16'hE05A -> 8'h0A
- arrow keys 16'hE075/E072/E06B/E074 -> 8'h11/12/13/14 (up/down/left/right)
REQ-017 SHALL silently discard unmapped make events and SHALL NOT set overflow for them.
REQ-018 SHALL emit every make event, including typematic repeats of a held key, as a separate character.
REQ-019 SHALL apply the shift state in effect before the current event; a shift make event itself produces no character.
REQ-020 SHALL push the translated character in the cycle new_key is high; for an empty FIFO, char_valid SHALL be high in the next cycle (latency 1) with char equal to the pushed value.
REQ-021 SHALL implement the FIFO as first-word-fall-through, with circular read/write pointers of clog2(FIFO_DEPTH) bits and an occupancy counter of clog2(FIFO_DEPTH)+1 bits; the pointers SHALL wrap from FIFO_DEPTH-1 to 0.
REQ-022 SHALL hold char stable while char_valid && !char_ready.
REQ-023 SHALL handle a push and a pop in the same cycle when full by accepting both: occupancy is unchanged and overflow is not set.
REQ-024 SHALL handle a push when full without a pop by dropping the character, leaving the FIFO contents unchanged and setting overflow to 1; overflow SHALL remain set until reset.
REQ-025 SHALL treat a pop with char_valid low as a no-op.

Reset
REQ-026 SHALL, while rst is high, asynchronously clear:
- both FIFO pointers and the occupancy counter
- shift_l and shift_r
- overflow
- char_valid
- char (to 8'h00)
REQ-027 SHALL, on reset mid-operation, discard all queued characters and any held shift state; the first event after rst deasserts is translated unshifted.

Verification
REQ-028 SHALL cover the following scenario: make 0x16, char_ready=1 -> char=8'h31 with char_valid high for exactly one cycle, one cycle after new_key.
REQ-029 SHALL cover the following scenario: make 0x12, make 0x46, break 0x12, make 0x46 -> chars 8'h28 then 8'h39; shift_active is 1 between the shift make and break events.
REQ-030 SHALL cover the following scenario: char_ready=0, five makes 0x16,0x1E,0x26,0x25,0x2E with FIFO_DEPTH=4 -> overflow=1; draining yields '1','2','3','4' and then char_valid=0.
REQ-031 SHALL cover the following scenario: FIFO full with char_ready=1 and a push in the same cycle -> occupancy stays 4, overflow stays 0, and order is preserved.
REQ-032 SHALL cover the following scenario: make 16'hE075, make 16'hE04A, make 0x1C (unmapped), break 0x16 -> exactly two chars, 8'h11 then 8'h2F.
REQ-033 SHALL cover the following scenario: three chars queued, shift held, pulse rst -> char_valid=0, shift_active=0, overflow=0; a subsequent make 0x3E yields '8'.
